// File: rtl/flash_arbiter.sv
// flash_arbiter: two-requester read arbiter in front of a single flash
// controller, one flash read outstanding at a time. Requester 0 is the
// audio player, requester 1 the secondary reader.
// Optional build macro FLASH_ARB_RR_EN: round-robin between simultaneous
// requesters. Without it, requester 0 always wins a simultaneous request.
//
// state     | meaning
// IDLE      | waiting for a request; accepts one combinationally
// ISSUE     | flsh_read held with latched address until controller accepts
// WAIT_DATA | waiting for read data, bounded by TIMEOUT cycles
module flash_arbiter #(
  parameter int ADDR_W  = 23,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_read,
  input  logic [ADDR_W-1:0] req0_address,
  input  logic [3:0]        req0_byteenable,
  output logic              req0_waitrequest,
  output logic [31:0]       req0_readdata,
  output logic              req0_readdatavalid,
  input  logic              req1_read,
  input  logic [ADDR_W-1:0] req1_address,
  input  logic [3:0]        req1_byteenable,
  output logic              req1_waitrequest,
  output logic [31:0]       req1_readdata,
  output logic              req1_readdatavalid,
  output logic              flsh_read,
  output logic [ADDR_W-1:0] flsh_address,
  output logic [3:0]        flsh_byteenable,
  input  logic              flsh_waitrequest,
  input  logic [31:0]       flsh_readdata,
  input  logic              flsh_readdatavalid,
  output logic              owner,
  output logic              timeout_err,
  output logic [7:0]        debug
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_owner;
  logic              r_timeout_err;
  logic              r_flsh_read;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;

  logic w_any;
  logic w_gnt1;
  logic w_idle;
  logic w_wait;
  logic w_last_cycle;

  assign w_any  = req0_read | req1_read;
  assign w_idle = (r_state == IDLE);
  assign w_wait = (r_state == WAIT_DATA);
  // r_cnt counts elapsed WAIT_DATA cycles minus one, so this is the
  // TIMEOUT-th cycle; a valid in this very cycle still wins
  assign w_last_cycle = (r_cnt == CNT_W'(TIMEOUT - 1));

`ifdef FLASH_ARB_RR_EN
  // simultaneous requests go to whoever did not own the last read
  assign w_gnt1 = req1_read & (~req0_read | ~r_owner);
`else
  assign w_gnt1 = req1_read & ~req0_read;
`endif

  // acceptance and data strobes are combinational and suppressed during reset
  assign req0_waitrequest   = ~(~rst & w_idle & w_any & ~w_gnt1);
  assign req1_waitrequest   = ~(~rst & w_idle & w_gnt1);
  assign req0_readdatavalid = ~rst & w_wait & flsh_readdatavalid & ~r_owner;
  assign req1_readdatavalid = ~rst & w_wait & flsh_readdatavalid &  r_owner;
  assign req0_readdata      = flsh_readdata;
  assign req1_readdata      = flsh_readdata;

  assign flsh_read       = r_flsh_read;
  assign flsh_address    = r_addr;
  assign flsh_byteenable = r_be;
  assign owner           = r_owner;
  assign timeout_err     = r_timeout_err;
  assign debug = {r_state, r_owner, r_timeout_err, flsh_waitrequest,
                  flsh_readdatavalid, req1_read, req0_read};

  // arbitration FSM with registered flash command, owner and sticky timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_owner       <= 1'b0;
      r_timeout_err <= 1'b0;
      r_flsh_read   <= 1'b0;
      r_addr        <= '0;
      r_be          <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner     <= w_gnt1;
            r_addr      <= w_gnt1 ? req1_address : req0_address;
            r_be        <= w_gnt1 ? req1_byteenable : req0_byteenable;
            r_flsh_read <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!flsh_waitrequest) begin
            r_flsh_read <= 1'b0;
            r_cnt       <= '0;
            r_state     <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (flsh_readdatavalid) begin
            r_state <= IDLE;
          end else if (w_last_cycle) begin
            r_timeout_err <= 1'b1;
            r_state       <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_flsh_read <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule
